// File: rtl/soc_system_flags_out_if.sv
// Avalon-MM write/read slave bus for the HPS-to-FPGA flag output PIO.
// Carries the select, strobe, address and data lines; clock and reset stay outside.
`timescale 1ns/1ps
interface soc_system_flags_out_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_flags_out.sv
// Flag output PIO: data register, auto-clearing pulse bits with a shared timer,
// optional atomic OUTSET/OUTCLEAR enabled by defining SOC_FLAGS_OUT_SETCLR_EN.
`timescale 1ns/1ps
module soc_system_flags_out #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  soc_system_flags_out_if.slave avs,
  output logic [WIDTH-1:0]     out_port
);

  localparam int             CW     = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0]  RELOAD = CW'(PULSE_CYCLES - 1);

  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] pend_q,  pend_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             wr;

  assign wr = avs.chipselect & ~avs.write_n;

  always_comb begin
    data_d = data_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;

    // Shared timer: pending bits drop together when the count reaches zero.
    if (pend_q != '0) begin
      if (cnt_q == '0) begin
        data_d = data_q & ~pend_q;
        pend_d = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    if (wr) begin
      case (avs.address)
        2'd0: begin
          data_d = avs.writedata;
          pend_d = '0;
          cnt_d  = '0;
        end
        2'd1: begin
          // Built from the pre-expiry state so a pulse on the expiry edge leaves no gap.
          if ((pend_q | avs.writedata) != '0) begin
            data_d = data_q | avs.writedata;
            pend_d = pend_q | avs.writedata;
            cnt_d  = RELOAD;
          end
        end
`ifdef SOC_FLAGS_OUT_SETCLR_EN
        2'd2: begin
          data_d = data_d | avs.writedata;
        end
        2'd3: begin
          data_d = data_d & ~avs.writedata;
          pend_d = pend_d & ~avs.writedata;
          if (pend_d == '0) cnt_d = '0;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (avs.address)
      2'd0:    rdata_d = data_q;
      2'd1:    rdata_d = pend_q;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE;
      pend_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign out_port     = data_q;
  assign avs.readdata = rdata_q;

endmodule

// File: tb/tb_soc_system_flags_out.sv
// Scoreboard bench for soc_system_flags_out: deadline-based reference model pushes
// expected out_port/readdata per edge; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_soc_system_flags_out;
  localparam int             W  = 32;
  localparam logic [W-1:0]   RV = 32'h0000_00A5;
  localparam int             PC = 16;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] out_port;

  soc_system_flags_out_if #(.WIDTH(W)) bus ();

  soc_system_flags_out #(
    .WIDTH(W), .RESET_VALUE(RV), .PULSE_CYCLES(PC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avs(bus), .out_port(out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out_v;
    logic [W-1:0] rd_v;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending bits expire at an absolute edge number (deadline).
  logic [W-1:0] m_data = RV;
  logic [W-1:0] m_pend = '0;
  longint       tick = 0;
  longint       deadline = 0;

  initial begin
    exp_t         e;
    logic         wr;
    logic [1:0]   a;
    logic [W-1:0] wd;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_data = RV;
        m_pend = '0;
        sb.delete();
      end else begin
        tick++;
        wr = bus.chipselect && !bus.write_n;
        a  = bus.address;
        wd = bus.writedata;
        e.rd_v = (a == 2'd0) ? m_data : (a == 2'd1) ? m_pend : '0;
        if (wr && a == 2'd0) begin
          m_data = wd;
          m_pend = '0;
        end else if (wr && a == 2'd1 && (m_pend | wd) != '0) begin
          m_data   = m_data | wd;
          m_pend   = m_pend | wd;
          deadline = tick + PC;
        end else begin
          if (m_pend != '0 && tick == deadline) begin
            m_data = m_data & ~m_pend;
            m_pend = '0;
          end
`ifdef SOC_FLAGS_OUT_SETCLR_EN
          if (wr && a == 2'd2) m_data = m_data | wd;
          if (wr && a == 2'd3) begin
            m_data = m_data & ~wd;
            m_pend = m_pend & ~wd;
          end
`endif
        end
        e.out_v = m_data;
        sb.push_back(e);
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("reset_out_port", out_port, RV);
        check("reset_readdata", bus.readdata, '0);
      end else if (sb.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_empty: got no expected entry, required one at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("out_port", out_port, e.out_v);
        check("readdata", bus.readdata, e.rd_v);
      end
    end
  end

  task automatic drive(input logic cs, input logic wn, input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    #2;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = d;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    drive(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a, input int n);
    repeat (n) drive(1'b0, 1'b1, a, $urandom);
  endtask

  initial begin
    logic [W-1:0] d;
    int           r;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = '0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    rd(2'd0, 2); rd(2'd1, 1); rd(2'd2, 1); rd(2'd3, 1);
    wr(2'd0, 32'h1234_5678); rd(2'd0, 2); rd(2'd1, 1);
    wr(2'd0, 32'h0); wr(2'd1, 32'h3); rd(2'd1, 20);
    wr(2'd1, 32'h1); rd(2'd0, 9); wr(2'd1, 32'h2); rd(2'd0, 20);
    // Second pulse lands exactly on the first one's expiry edge
    wr(2'd1, 32'h1); rd(2'd0, 15); wr(2'd1, 32'h4); rd(2'd1, 20);
    wr(2'd1, 32'h0); rd(2'd1, 3);
    wr(2'd1, 32'h8); rd(2'd1, 5); wr(2'd1, 32'h0); rd(2'd1, 20);
    wr(2'd0, 32'h0000_0F00); wr(2'd1, 32'h0000_0300); rd(2'd0, 20);
    wr(2'd1, 32'hF); rd(2'd0, 5); wr(2'd0, 32'h100); rd(2'd0, 20);
    drive(1'b0, 1'b0, 2'd0, 32'hDEAD_BEEF); drive(1'b1, 1'b1, 2'd0, 32'hCAFE_F00D); rd(2'd0, 2);
    wr(2'd0, 32'hF0); wr(2'd2, 32'h0F); rd(2'd0, 1); wr(2'd3, 32'h81); rd(2'd0, 2);
    wr(2'd1, 32'h3); rd(2'd1, 15); wr(2'd2, 32'h10); rd(2'd1, 3);
    wr(2'd1, 32'h3); rd(2'd1, 4); wr(2'd3, 32'h1); rd(2'd1, 4); wr(2'd3, 32'h2); rd(2'd1, 20);
    wr(2'd1, 32'h6); rd(2'd1, 15); wr(2'd3, 32'h2); rd(2'd1, 4);

    // Asynchronous reset in the middle of a pulse
    wr(2'd1, 32'hF); rd(2'd0, 5);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_out_port", out_port, RV);
    check("async_reset_readdata", bus.readdata, '0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    rd(2'd1, 20);

    repeat (3000) begin
      r = $urandom_range(0, 9);
      d = (r[0]) ? ($urandom & 32'h0000_00FF) : $urandom;
      if (r < 3) wr(2'($urandom_range(0, 3)), d);
      else if (r == 3) wr(2'd1, d & 32'h0000_000F);
      else if (r == 4) drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), d);
      else rd(2'($urandom_range(0, 3)), 1);
    end

    rd(2'd0, 2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
